// File: rtl/motor_pwm_if.sv
// Bundle of motor_pwm command inputs and PWM/status outputs.
// The master drives speed/dir/en; the slave (motor_pwm) returns the wheel waveforms.
interface motor_pwm_if;
  logic       en;
  logic [3:0] speed;
  logic [3:0] dir;
  logic       pwm_l;
  logic       pwm_r;
  logic [3:0] duty_l;
  logic [3:0] duty_r;
  logic       period_start;
  logic       active;

  modport master (
    output en, speed, dir,
    input  pwm_l, pwm_r, duty_l, duty_r, period_start, active
  );

  modport slave (
    input  en, speed, dir,
    output pwm_l, pwm_r, duty_l, duty_r, period_start, active
  );
endinterface

// File: rtl/motor_pwm.sv
// Differential-drive PWM generator: turns speed/direction codes into left/right
// duties and emits two registered PWM waveforms that relatch only at period wrap.
module motor_pwm #(
  parameter int PRESCALE   = 4,
  parameter int CENTER_DIR = 8
) (
  input  logic       clk,
  input  logic       rst,
  motor_pwm_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [3:0]       CNT_LAST = 4'd14;
  localparam logic [4:0]       CENTER_5 = 5'(CENTER_DIR);

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       duty_l_q, duty_l_d;
  logic [3:0]       duty_r_q, duty_r_d;
  logic             period_start_q, period_start_d;
  logic             pwm_l_q, pwm_l_d;
  logic             pwm_r_q, pwm_r_d;

  // Steering: the wheel on the inside of the turn slows by |dir - CENTER_DIR|.
  logic [4:0] diff;
  logic [4:0] off_full;
  logic [3:0] off;
  logic [3:0] inner;
  logic [3:0] new_duty_l;
  logic [3:0] new_duty_r;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    diff       = {1'b0, bus.dir} - CENTER_5;
    off_full   = diff[4] ? (5'd0 - diff) : diff;
    off        = off_full[3:0];
    inner      = (bus.speed > off) ? (bus.speed - off) : 4'd0;
    new_duty_l = bus.speed;
    new_duty_r = bus.speed;
    if (diff[4]) begin
      new_duty_l = inner;
    end else if (diff != 5'd0) begin
      new_duty_r = inner;
    end
  end

  always_comb begin
    state_d        = state_q;
    pre_d          = pre_q;
    cnt_d          = cnt_q;
    duty_l_d       = duty_l_q;
    duty_r_d       = duty_r_q;
    period_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d        = RUN;
          pre_d          = '0;
          cnt_d          = '0;
          duty_l_d       = new_duty_l;
          duty_r_d       = new_duty_r;
          period_start_d = 1'b1;
        end
      end
      RUN: begin
        if (!bus.en) begin
          // Disable wins over a simultaneous wrap: no relatch, no period_start.
          state_d  = IDLE;
          pre_d    = '0;
          cnt_d    = '0;
          duty_l_d = '0;
          duty_r_d = '0;
        end else if (pre_q == PRE_LAST) begin
          pre_d = '0;
          if (cnt_q == CNT_LAST) begin
            cnt_d          = '0;
            duty_l_d       = new_duty_l;
            duty_r_d       = new_duty_r;
            period_start_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // PWM is decoded from next-state values and registered, so the pins never glitch.
    pwm_l_d = (state_d == RUN) && (cnt_d < duty_l_d);
    pwm_r_d = (state_d == RUN) && (cnt_d < duty_r_d);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pre_q          <= '0;
      cnt_q          <= '0;
      duty_l_q       <= '0;
      duty_r_q       <= '0;
      period_start_q <= 1'b0;
      pwm_l_q        <= 1'b0;
      pwm_r_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pre_q          <= pre_d;
      cnt_q          <= cnt_d;
      duty_l_q       <= duty_l_d;
      duty_r_q       <= duty_r_d;
      period_start_q <= period_start_d;
      pwm_l_q        <= pwm_l_d;
      pwm_r_q        <= pwm_r_d;
    end
  end

  assign bus.pwm_l        = pwm_l_q;
  assign bus.pwm_r        = pwm_r_q;
  assign bus.duty_l       = duty_l_q;
  assign bus.duty_r       = duty_r_q;
  assign bus.period_start = period_start_q;
  assign bus.active       = (state_q == RUN);

endmodule

// File: tb/tb_motor_pwm.sv
// Directed bench for motor_pwm: steering table on a PRESCALE=1 instance plus
// hand sequences for mid-period change, disable/wrap, prescale and async reset.
module tb_motor_pwm;

  logic clk;
  logic rst;

  motor_pwm_if bus_p1 ();
  motor_pwm_if bus_p4 ();

  motor_pwm #(.PRESCALE(1), .CENTER_DIR(8)) u_dut_p1 (
    .clk (clk),
    .rst (rst),
    .bus (bus_p1)
  );

  motor_pwm #(.PRESCALE(4), .CENTER_DIR(8)) u_dut_p4 (
    .clk (clk),
    .rst (rst),
    .bus (bus_p4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] speed;
    logic [3:0] dir;
    int         exp_l;
    int         exp_r;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_p1(input string tag);
    check({tag, "_pwm_l"},        int'(bus_p1.pwm_l),        0);
    check({tag, "_pwm_r"},        int'(bus_p1.pwm_r),        0);
    check({tag, "_duty_l"},       int'(bus_p1.duty_l),       0);
    check({tag, "_duty_r"},       int'(bus_p1.duty_r),       0);
    check({tag, "_period_start"}, int'(bus_p1.period_start), 0);
    check({tag, "_active"},       int'(bus_p1.active),       0);
  endtask

  // Walks the PRESCALE=1 instance from cnt=start_k to the next wrap, comparing
  // each PWM sample against cnt<duty and expecting period_start only at the wrap.
  task automatic check_period_p1(input int start_k, input int dl, input int dr, input string tag);
    int err_l = 0;
    int err_r = 0;
    int ps    = 0;
    for (int k = start_k; k < 15; k++) begin
      if (int'(bus_p1.pwm_l) != int'(k < dl)) err_l++;
      if (int'(bus_p1.pwm_r) != int'(k < dr)) err_r++;
      if (k > 0 && bus_p1.period_start) ps++;
      tick();
    end
    check({tag, "_pwm_l_pattern_errs"}, err_l, 0);
    check({tag, "_pwm_r_pattern_errs"}, err_r, 0);
    check({tag, "_early_period_start"}, ps, 0);
    check({tag, "_wrap_period_start"},  int'(bus_p1.period_start), 1);
  endtask

  initial begin
    vecs[0] = '{speed: 4'd10, dir: 4'd8,  exp_l: 10, exp_r: 10};
    vecs[1] = '{speed: 4'd10, dir: 4'd5,  exp_l: 7,  exp_r: 10};
    vecs[2] = '{speed: 4'd5,  dir: 4'd0,  exp_l: 0,  exp_r: 5};
    vecs[3] = '{speed: 4'd15, dir: 4'd15, exp_l: 15, exp_r: 8};
    vecs[4] = '{speed: 4'd2,  dir: 4'd12, exp_l: 2,  exp_r: 0};
    vecs[5] = '{speed: 4'd3,  dir: 4'd9,  exp_l: 3,  exp_r: 2};
    vecs[6] = '{speed: 4'd15, dir: 4'd8,  exp_l: 15, exp_r: 15};

    rst          = 1'b1;
    bus_p1.en    = 1'b0;
    bus_p1.speed = 4'd0;
    bus_p1.dir   = 4'd8;
    bus_p4.en    = 1'b0;
    bus_p4.speed = 4'd0;
    bus_p4.dir   = 4'd8;

    #2;
    check_idle_p1("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_idle_p1("idle_en0");

    // Steering table: each vector runs one full period and is then disabled.
    foreach (vecs[i]) begin
      bus_p1.speed = vecs[i].speed;
      bus_p1.dir   = vecs[i].dir;
      bus_p1.en    = 1'b1;
      tick();
      check($sformatf("vec%0d_start", i),  int'(bus_p1.period_start), 1);
      check($sformatf("vec%0d_active", i), int'(bus_p1.active),       1);
      check($sformatf("vec%0d_duty_l", i), int'(bus_p1.duty_l),       vecs[i].exp_l);
      check($sformatf("vec%0d_duty_r", i), int'(bus_p1.duty_r),       vecs[i].exp_r);
      check_period_p1(0, vecs[i].exp_l, vecs[i].exp_r, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_second_period_start", i), int'(bus_p1.period_start), 1);
      bus_p1.en = 1'b0;
      tick();
      check($sformatf("vec%0d_off_active", i), int'(bus_p1.active), 0);
    end

    // Mid-period change: speed drops at cnt=5 but takes effect only at the wrap.
    bus_p1.speed = 4'd10;
    bus_p1.dir   = 4'd8;
    bus_p1.en    = 1'b1;
    tick();
    repeat (5) tick();
    bus_p1.speed = 4'd3;
    check("mid_duty_held", int'(bus_p1.duty_l), 10);
    check_period_p1(5, 10, 10, "mid_cur");
    check("mid_duty_l_new", int'(bus_p1.duty_l), 3);
    check("mid_duty_r_new", int'(bus_p1.duty_r), 3);
    check_period_p1(0, 3, 3, "mid_next");

    // Disable at cnt=7, then re-enable restarts the period from cnt=0.
    bus_p1.en    = 1'b0;
    tick();
    bus_p1.speed = 4'd10;
    bus_p1.en    = 1'b1;
    tick();
    repeat (7) tick();
    bus_p1.en = 1'b0;
    tick();
    check_idle_p1("dis_cnt7");
    tick();
    check_idle_p1("dis_hold");
    bus_p1.en = 1'b1;
    tick();
    check("reen_start",  int'(bus_p1.period_start), 1);
    check("reen_duty_l", int'(bus_p1.duty_l),       10);
    check_period_p1(0, 10, 10, "reen");

    // Disable on the wrap edge: en=0 wins, no period_start, no relatch.
    repeat (14) tick();
    bus_p1.speed = 4'd7;
    bus_p1.en    = 1'b0;
    tick();
    check_idle_p1("wrap_drop");

    // PRESCALE=4: 60-clock period, each PWM high for the first 4 clocks.
    bus_p4.speed = 4'd1;
    bus_p4.dir   = 4'd8;
    bus_p4.en    = 1'b1;
    tick();
    check("p4_start",  int'(bus_p4.period_start), 1);
    check("p4_duty_l", int'(bus_p4.duty_l),       1);
    begin
      int hi_l = 0;
      int hi_r = 0;
      int err  = 0;
      int ps   = 0;
      for (int k = 0; k < 60; k++) begin
        if (bus_p4.pwm_l) hi_l++;
        if (bus_p4.pwm_r) hi_r++;
        if (int'(bus_p4.pwm_l) != int'(k < 4)) err++;
        if (k > 0 && bus_p4.period_start) ps++;
        tick();
      end
      check("p4_high_l",      hi_l, 4);
      check("p4_high_r",      hi_r, 4);
      check("p4_pattern_err", err,  0);
      check("p4_early_start", ps,   0);
      check("p4_wrap_start",  int'(bus_p4.period_start), 1);
    end
    bus_p4.en = 1'b0;
    tick();
    check("p4_off_active", int'(bus_p4.active), 0);

    // Asynchronous reset mid-RUN, asserted between clock edges.
    bus_p1.speed = 4'd15;
    bus_p1.dir   = 4'd8;
    bus_p1.en    = 1'b1;
    tick();
    repeat (3) tick();
    check("pre_rst_active", int'(bus_p1.active), 1);
    #3;
    rst = 1'b1;
    #1;
    check_idle_p1("async_rst");
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("rst_hold%0d_active", c), int'(bus_p1.active), 0);
      check($sformatf("rst_hold%0d_pwm_l", c),  int'(bus_p1.pwm_l),  0);
    end
    #2;
    rst = 1'b0;
    tick();
    check("post_rst_start", int'(bus_p1.period_start), 1);
    check("post_rst_pwm_l", int'(bus_p1.pwm_l),        1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_pwm.md
# motor_pwm

Differential-drive PWM generator that sits directly downstream of the proportional motion controller. It consumes the controller's 4-bit speed and 4-bit direction codes and converts them into left and right wheel duty cycles with a differential-steering rule. It generates two glitch-free PWM waveforms whose duties update only on PWM period boundaries.

## Interface
- PRESCALE, 4: clocks per PWM tick; legal range ≥1.
- CENTER_DIR, 8: direction code meaning straight ahead; legal range 0..15.

- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high. One clock, `clk`.
- en  in  1  run enable.
- speed  in  4  commanded speed (controller `speed_o`).
- dir  in  4  commanded direction (controller `dir_o`). Below CENTER_DIR steers left; above steers right.
- pwm_l  out  1  left wheel PWM.
- pwm_r  out  1  right wheel PWM.
- duty_l  out  4  left duty currently in force.
- duty_r  out  4  right duty currently in force.
- period_start  out  1  one-clock pulse on the first clock of each PWM period.
- active  out  1  generator running.

## Operation
- Registers:
  - `active`.
  - Prescaler `pre`, counting 0..PRESCALE-1.
  - Period counter `cnt`, counting 0..14.
  - `duty_l`, `duty_r`.
  - `period_start`.
- Duty computation (combinational, from live inputs):
  - diff = dir − CENTER_DIR, computed as a 5-bit signed value.
  - off = |diff|.
  - inner = (speed > off) ? speed − off : 0. No underflow.
  - outer = speed.
  - diff < 0: duty_l = inner, duty_r = outer.
  - diff > 0: duty_l = outer, duty_r = inner.
  - diff = 0: both duties = speed.
- Two states, IDLE (active=0) and RUN (active=1).
- IDLE → RUN, on a clock edge with en=1:
  - Latch the computed duties.
  - pre ← 0, cnt ← 0.
  - period_start ← 1.
  - active ← 1.
- RUN, each clock with en=1:
  - pre < PRESCALE-1: pre increments.
  - pre = PRESCALE-1: pre ← 0 and cnt advances.
  - cnt at 14 when it advances: wraps to 0, duties relatch from live inputs, period_start ← 1.
  - period_start is 0 on every other clock.
- RUN → IDLE, on a clock edge with en=0:
  - active, pre, cnt, duty_l, duty_r, period_start all ← 0.
  - No period completion.
- IDLE with en=0: all registers hold at 0.
- PWM outputs:
  - pwm_l = active & (cnt < duty_l).
  - pwm_r = active & (cnt < duty_r).
  - Decoded from registers only; no input feeds these outputs combinationally.
- Duty extremes:
  - Duty 0: output constantly low.
  - Duty 15: output constantly high across the whole period.
- Input changes mid-period have no effect until the next period_start.

## Timing
- Reset (asynchronous, immediate): every output and register = 0, state IDLE. Applies mid-period too.
- Period length is 15×PRESCALE clocks.
- High time per period is duty×PRESCALE clocks, starting at the period's first clock.
- Latency from en sampled high to first PWM high clock: 1 clock. period_start, active and the new duties all appear in that same cycle.
- Latency from en sampled low to outputs low: 1 clock.
- period_start pulses exactly 15×PRESCALE clocks apart while en stays high.
- When en and the period wrap occur in the same cycle, en=0 wins: state goes IDLE with no relatch.
- Re-enable restarts at cnt=0 with freshly latched duties. No memory of the prior phase.

## Test plan
- **Reset:** assert rst mid-RUN, asynchronously between clock edges → all outputs 0 before the next edge. Hold rst 3 cycles → outputs remain 0.
- **Straight, PRESCALE=1:**
  - Stimulus: en=1, speed=10, dir=8.
  - period_start one clock after the en edge.
  - duty_l = duty_r = 10.
  - Both PWMs high 10 of every 15 clocks.
  - period_start repeats every 15 clocks.
- **Steering arithmetic:**
  - speed=10, dir=5 → duty_l=7, duty_r=10.
  - speed=5, dir=0 → duty_l=0 (pwm_l never high), duty_r=5.
  - speed=15, dir=15 → duty_l=15 (pwm_l constant high), duty_r=8.
  - speed=2, dir=12 → duty_l=2, duty_r=0.
- **Mid-period change:**
  - Stimulus: change speed 10→3 at cnt=5.
  - Current period keeps duty 10.
  - duty becomes 3 at the next period_start, 15 clocks after the previous one.
- **Disable/re-enable:**
  - Drop en at cnt=7 → next clock pwm_l=pwm_r=0, active=0, duties=0.
  - Raise en again → period_start next clock, cnt restarts at 0.
  - Drop en in the wrap cycle → no period_start.
- **Prescale:** PRESCALE=4, speed=1, dir=8 → period 60 clocks, each PWM high for exactly 4 clocks per period.
